// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers used by the arbiter, the masters and the bridge.
package ahb_pkg;

    localparam int unsigned MAX_MASTERS = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    function automatic logic [MAX_MASTERS-1:0] ONE_HOT(input int unsigned idx);
        return MAX_MASTERS'(1) << idx;
    endfunction

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping; master 0 when idle.
module rr_pick
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          last,
    output logic [MW-1:0]          winner,
    output logic                   any
);

    logic [MW-1:0]          cand [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] hit;

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_cand
        assign cand[k] = MW'((32'(last) + k + 1) % NUM_MASTERS);
        assign hit[k]  = req[cand[k]];
    end

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (!any && hit[k]) begin
                winner = cand[k];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with tenure limit; muxes the owner's address/control and the
// data-phase owner's write data onto the single bridge slave port.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 3,
    parameter  int unsigned MAX_BEATS   = 16,
    localparam int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic [NUM_MASTERS-1:0]    hbusreq,
    input  logic [32*NUM_MASTERS-1:0] m_haddr,
    input  logic [2*NUM_MASTERS-1:0]  m_htrans,
    input  logic [NUM_MASTERS-1:0]    m_hwrite,
    input  logic [32*NUM_MASTERS-1:0] m_hwdata,
    output logic [NUM_MASTERS-1:0]    hgrant,
    output logic [MW-1:0]             hmaster,
    output logic [31:0]               haddr,
    output logic [1:0]                htrans,
    output logic                      hwrite,
    output logic [31:0]               hwdata,
    output logic                      hreadyin,
    input  logic                      hreadyout,
    input  logic [1:0]                hresp,
    input  logic [31:0]               hrdata
);

    localparam int unsigned TW    = $clog2(MAX_BEATS + 1);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_BEATS);

    logic [31:0] haddr_a  [NUM_MASTERS];
    logic [1:0]  htrans_a [NUM_MASTERS];
    logic        hwrite_a [NUM_MASTERS];
    logic [31:0] hwdata_a [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign haddr_a[g]  = m_haddr[32*g +: 32];
        assign htrans_a[g] = m_htrans[2*g +: 2];
        assign hwrite_a[g] = m_hwrite[g];
        assign hwdata_a[g] = m_hwdata[32*g +: 32];
    end

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [MW-1:0]          last_owner_q, last_owner_d;
    logic [MW-1:0]          dp_master_q;
    logic                   dp_valid_q;
    logic [TW-1:0]          tenure_q, tenure_d;

    logic [1:0]             own_trans;
    logic                   at_boundary;
    logic [NUM_MASTERS-1:0] other_req;
    logic                   handover_ok;
    logic [MW-1:0]          pick_winner;
    logic                   pick_any;
    logic [MW-1:0]          win_idx;
    logic [MAX_MASTERS-1:0] win_oh;

    assign own_trans   = htrans_a[hmaster_q];
    assign at_boundary = (own_trans == HTRANS_IDLE) || (own_trans == HTRANS_NONSEQ);
    assign other_req   = hbusreq & ~grant_q;
    assign handover_ok = at_boundary &&
                         (!hbusreq[hmaster_q] || ((|other_req) && (tenure_q >= MAX_T)));

    // The owner is masked out of the pick so a tenure-forced handover always rotates
    // onward; when the owner has dropped its request the mask changes nothing.
    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_rr_pick (
        .req    (other_req),
        .last   (last_owner_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign win_idx = pick_any ? pick_winner : '0;
    assign win_oh  = ONE_HOT(32'(win_idx));

    always_comb begin
        grant_d      = grant_q;
        hmaster_d    = hmaster_q;
        last_owner_d = last_owner_q;
        tenure_d     = tenure_q;
        if (is_active(own_trans) && (tenure_q != MAX_T)) begin
            tenure_d = tenure_q + 1'b1;
        end
        if (handover_ok && (win_idx != hmaster_q)) begin
            grant_d      = win_oh[NUM_MASTERS-1:0];
            hmaster_d    = win_idx;
            last_owner_d = hmaster_q;
            tenure_d     = '0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            grant_q      <= NUM_MASTERS'(1);
            hmaster_q    <= '0;
            last_owner_q <= MW'(NUM_MASTERS - 1);
            dp_master_q  <= '0;
            dp_valid_q   <= 1'b0;
            tenure_q     <= '0;
        end else if (hreadyout) begin
            grant_q      <= grant_d;
            hmaster_q    <= hmaster_d;
            last_owner_q <= last_owner_d;
            dp_master_q  <= hmaster_q;
            dp_valid_q   <= is_active(htrans);
            tenure_q     <= tenure_d;
        end
    end

    assign hgrant   = grant_q;
    assign hmaster  = hmaster_q;
    assign haddr    = haddr_a[hmaster_q];
    assign htrans   = htrans_a[hmaster_q];
    assign hwrite   = hwrite_a[hmaster_q];
    assign hwdata   = hwdata_a[dp_master_q];
    assign hreadyin = hreadyout;

    // Response path reaches the masters directly; dp_valid is kept as pipeline status only.
    logic unused_sink;
    assign unused_sink = ^{dp_valid_q, hresp, hrdata, win_oh};

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, single requester, rotation, tenure limit,
// async reset and wait states, with hand-derived expectations.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    localparam int unsigned NM = 3;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic [NM-1:0]     hbusreq;
    logic [32*NM-1:0]  m_haddr;
    logic [2*NM-1:0]   m_htrans;
    logic [NM-1:0]     m_hwrite;
    logic [32*NM-1:0]  m_hwdata;
    logic [NM-1:0]     hgrant;
    logic [1:0]        hmaster;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [31:0]       hwdata;
    logic              hreadyin;
    logic              hreadyout;
    logic [1:0]        hresp;
    logic [31:0]       hrdata;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_bus_arbiter #(
        .NUM_MASTERS (3),
        .MAX_BEATS   (16)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .m_haddr   (m_haddr),
        .m_htrans  (m_htrans),
        .m_hwrite  (m_hwrite),
        .m_hwdata  (m_hwdata),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hreadyin  (hreadyin),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int unsigned m, input logic req, input logic [1:0] tr,
                       input logic wr, input logic [31:0] a, input logic [31:0] d);
        hbusreq[m]          = req;
        m_htrans[2*m +: 2]  = tr;
        m_hwrite[m]         = wr;
        m_haddr[32*m +: 32] = a;
        m_hwdata[32*m +: 32] = d;
    endtask

    task automatic clear_all();
        hbusreq   = '0;
        m_haddr   = '0;
        m_htrans  = '0;
        m_hwrite  = '0;
        m_hwdata  = '0;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned beat [NM];
        int unsigned exp_m;
        int unsigned start;
        int unsigned k;

        hresetn = 1'b0;
        clear_all();

        // Reset values
        @(negedge hclk);
        chk("rst_hgrant", hgrant, 3'b001);
        chk("rst_hmaster", hmaster, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_htrans", htrans, HTRANS_IDLE);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hreadyin", hreadyin, 1);
        hresetn = 1'b1;

        // No requests: default master 0 holds for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge hclk);
            chk("idle_hgrant", hgrant, 3'b001);
            chk("idle_hmaster", hmaster, 0);
            chk("idle_htrans", htrans, HTRANS_IDLE);
        end

        // Single requester: master 1
        drv(1, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
        @(negedge hclk);
        chk("single_hgrant", hgrant, 3'b010);
        chk("single_hmaster", hmaster, 1);
        drv(1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h8000_0004, 32'h0);
        #1;
        chk("single_haddr", haddr, 32'h8000_0004);
        chk("single_htrans", htrans, HTRANS_NONSEQ);
        chk("single_hwrite", hwrite, 1);
        @(negedge hclk);
        drv(1, 1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'hA5A5_0001);
        #1;
        chk("single_hwdata", hwdata, 32'hA5A5_0001);
        chk("single_hold", hmaster, 1);
        @(negedge hclk);
        chk("single_release_hgrant", hgrant, 3'b001);
        chk("single_release_hmaster", hmaster, 0);
        chk("single_last_hwdata", hwdata, 32'hA5A5_0001);
        drv(1, 1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);

        // Contention from reset: 4-beat INCR bursts, 16-beat tenure, order 0,1,2,0
        hresetn = 1'b0;
        clear_all();
        @(negedge hclk);
        hresetn = 1'b1;
        for (int m = 0; m < NM; m++) beat[m] = 0;
        for (int n = 0; n <= 60; n++) begin
            if (n > 0) @(negedge hclk);
            exp_m = (n < 17) ? 0 : (n < 34) ? 1 : (n < 51) ? 2 : 0;
            start = (n < 17) ? 0 : (n < 34) ? 17 : (n < 51) ? 34 : 51;
            chk("rr_hmaster", hmaster, exp_m);
            chk("rr_hgrant", hgrant, 64'(1) << exp_m);
            for (int unsigned m = 0; m < NM; m++) begin
                if (hgrant[m]) begin
                    drv(m, 1'b1, (beat[m] % 4 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0,
                        32'h1000_0000 * (m + 1) + 4 * beat[m], 32'h0);
                    beat[m]++;
                end else begin
                    drv(m, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
                    beat[m] = 0;
                end
            end
            #1;
            chk("rr_haddr", haddr, 32'h1000_0000 * (exp_m + 1) + 4 * (n - start));
        end

        // Tenure limit: master 0 undefined INCR, master 2 waits
        hresetn = 1'b0;
        clear_all();
        @(negedge hclk);
        hresetn = 1'b1;
        for (int unsigned n = 0; n <= 27; n++) begin
            if (n > 0) @(negedge hclk);
            exp_m = (n <= 20) ? 0 : 2;
            chk("ten_hmaster", hmaster, exp_m);
            chk("ten_hgrant", hgrant, (n <= 20) ? 3'b001 : 3'b100);
            if (n <= 20)
                drv(0, 1'b1, (n == 0 || n == 20) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0,
                    32'h2000_0000 + 4 * n, 32'h0);
            else
                drv(0, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
            if (n >= 21) begin
                k = n - 21;
                drv(2, 1'b1, (k == 0 || k == 4) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0,
                    32'h2200_0000 + 4 * k, 32'h0);
            end else begin
                drv(2, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
            end
            #1;
            chk("ten_haddr", haddr, (n <= 20) ? 32'h2000_0000 + 4 * n
                                              : 32'h2200_0000 + 4 * (n - 21));
        end

        // Async reset mid-burst with master 2 owning, no clock edge in between
        #1;
        hresetn = 1'b0;
        #1;
        chk("arst_hgrant", hgrant, 3'b001);
        chk("arst_hmaster", hmaster, 0);
        chk("arst_haddr", haddr, 0);
        chk("arst_htrans", htrans, HTRANS_IDLE);
        chk("arst_hwdata", hwdata, 0);

        // Wait states across a handover edge
        @(negedge hclk);
        clear_all();
        hresetn = 1'b1;
        drv(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h3000_0000, 32'h0);
        drv(1, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
        @(negedge hclk);
        chk("ws_start_hmaster", hmaster, 0);
        drv(0, 1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'hD0D0_0000);
        hreadyout = 1'b0;
        #1;
        chk("ws_hwdata_first", hwdata, 32'hD0D0_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            chk("ws_hold_hgrant", hgrant, 3'b001);
            chk("ws_hold_hmaster", hmaster, 0);
            chk("ws_hold_hwdata", hwdata, 32'hD0D0_0000);
            chk("ws_hreadyin", hreadyin, 0);
        end
        hreadyout = 1'b1;
        @(negedge hclk);
        chk("ws_handover_hgrant", hgrant, 3'b010);
        chk("ws_handover_hmaster", hmaster, 1);
        chk("ws_old_owner_hwdata", hwdata, 32'hD0D0_0000);
        chk("ws_hreadyin_hi", hreadyin, 1);
        drv(1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h4000_0010, 32'h0);
        #1;
        chk("ws_new_haddr", haddr, 32'h4000_0010);
        chk("ws_new_htrans", htrans, HTRANS_NONSEQ);
        @(negedge hclk);
        drv(0, 1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'hB1B1_0002);
        #1;
        chk("ws_new_hwdata", hwdata, 32'hB1B1_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
